piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in, serial-out shift register. It is the transmit end of the serial links fed
//  into our serial-in shift-register chains: a WIDTH-bit word is accepted by a valid/ready
//  handshake and driven out one bit per clk, with an optional even-parity bit appended.
//  Back-to-back loads give gapless frames.
// PARAMETERS
//  WIDTH      8  data word width in bits (>=2)
//  MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  PAR_EN     0  1: append an even-parity bit after the data; frame length FLEN = WIDTH+PAR_EN
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  load_valid  in   1      load_data is valid
//  load_data   in   WIDTH  word to serialize; sampled only on accept
//  load_ready  out  1      serializer can take a word this cycle
//  sout        out  1      serial data bit
//  sout_valid  out  1      sout carries a frame bit this cycle
//  frame_start out  1      high during the first bit of each frame
//  frame_done  out  1      high during the last bit of each frame (parity bit when PAR_EN=1)
//  busy        out  1      state == SHIFT
// BEHAVIOUR
//  - Internal state: FSM {IDLE, SHIFT}; shift_reg[WIDTH-1:0]; par_bit;
//    bit_cnt of $clog2(FLEN) bits (minimum 1 bit).
//  - accept = load_valid & load_ready & ~rst.
//    load_ready = ~rst & (IDLE | (SHIFT & bit_cnt==FLEN-1)). It is combinational from
//    registered state and does not depend on load_valid.
//  - Reset (rst=1 at a clk edge):
//    - state = IDLE; shift_reg, bit_cnt and par_bit are 0.
//    - Outputs: sout=0, sout_valid=0, frame_start=0, frame_done=0, busy=0, load_ready=0
//      while rst is high.
//    - Reset mid-frame aborts the frame. No further bits are sent.
//  - IDLE:
//    - On accept: shift_reg <= load_data; par_bit <= ^load_data; bit_cnt <= 0;
//      state <= SHIFT.
//    - Otherwise hold.
//  - SHIFT: one frame bit per cycle.
//    - Data bits: sout = shift_reg[WIDTH-1] when MSB_FIRST=1, else shift_reg[0].
//    - Parity bit: when PAR_EN=1 and bit_cnt==WIDTH, sout = par_bit.
//    - Each edge with bit_cnt < FLEN-1: bit_cnt++. shift_reg shifts toward the output end
//      and fills with 0 (left shift when MSB_FIRST=1, right shift otherwise).
//    - Edge with bit_cnt == FLEN-1:
//      - accept: reload exactly as in IDLE and stay in SHIFT (no idle gap).
//      - no accept: state <= IDLE.
//  - Latency: accept at edge N puts bit 0 of the frame on sout in the cycle after edge N.
//    The last frame bit is in the cycle after edge N+FLEN-1.
//  - Outputs are functions of registered state only; no input reaches an output
//    combinationally:
//    - sout_valid = busy = (state == SHIFT).
//    - frame_start = SHIFT & bit_cnt==0.
//    - frame_done = SHIFT & bit_cnt==FLEN-1.
//    - sout = 0 whenever sout_valid=0.
//  - load_data that changes while no accept occurs has no effect.
//    load_valid in SHIFT before the last bit is not accepted; the source must hold it.
//  - Simultaneous rst and load_valid: rst wins and the word is dropped.
// TESTING (WIDTH=8 unless noted; check every cycle against a reference model)
//  1. Reset: rst=1 for 2 edges with load_valid=1 -> sout=0, sout_valid=0, load_ready=0,
//     busy=0, and nothing is accepted.
//  2. MSB_FIRST=1, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 in the 8 cycles after accept.
//     frame_start in cycle 1, frame_done in cycle 8, then IDLE with sout_valid=0.
//  3. MSB_FIRST=0, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 (LSB first). Then load 8'h0F ->
//     1,1,1,1,0,0,0,0.
//  4. PAR_EN=1: load 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1 (9 bits, frame_done on bit 9).
//     Load 8'hA5 -> parity bit 0.
//  5. Back-to-back: load_valid held high with 8'hFF then 8'h00 (second word presented
//     during the last bit) -> 16 contiguous valid bits, frame_start at bits 1 and 9,
//     no gap.
//  6. Reset mid-frame: assert rst during bit 4 of 8'hA5 -> next cycle sout_valid=0, IDLE.
//     A new load of 8'h3C then serializes cleanly from bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per clock, optionally followed by an even-parity bit.
module piso_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          PAR_EN    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   localparam int unsigned FLEN  = WIDTH + (PAR_EN ? 1 : 0);
   localparam int unsigned CNT_W = (FLEN > 2) ? $clog2(FLEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLEN - 1);
   localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic             par_bit;
   logic [CNT_W-1:0] bit_cnt;

   logic             in_shift;
   logic             last_bit;
   logic             accept;
   logic             data_bit;
   logic             par_sel;
   logic [WIDTH-1:0] shifted;

   assign in_shift   = (state == SHIFT);
   assign last_bit   = in_shift && (bit_cnt == LAST_IDX);
   assign load_ready = ~rst & (~in_shift | last_bit);
   assign accept     = load_valid & load_ready;

   // Output end of the register and the zero-filling shift toward it
   assign data_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
   assign shifted  = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};
   assign par_sel  = PAR_EN && (bit_cnt == PAR_IDX);

   assign busy        = in_shift;
   assign sout_valid  = in_shift;
   assign frame_start = in_shift && (bit_cnt == '0);
   assign frame_done  = last_bit;
   assign sout        = in_shift & (par_sel ? par_bit : data_bit);

   // Frame sequencer; a word accepted on the last bit reloads without an idle gap
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         par_bit   <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg <= load_data;
                  par_bit   <= ^load_data;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (!last_bit) begin
                  bit_cnt   <= bit_cnt + CNT_W'(1);
                  shift_reg <= shifted;
               end else if (accept) begin
                  shift_reg <= load_data;
                  par_bit   <= ^load_data;
                  bit_cnt   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations (MSB-first, LSB-first, MSB-first+parity)
// driven independently, each checked bit-by-bit against a queue of expected frame bits.
module tb_piso_serializer;

   localparam int unsigned W = 8;
   localparam int unsigned N = 3;

   typedef struct {
      logic b;
      logic first;
      logic last;
   } exp_bit_t;

   logic         clk;
   logic         rst_s [N];
   logic         lv    [N];
   logic [W-1:0] ld    [N];
   logic         rdy   [N];
   logic         so    [N];
   logic         sov   [N];
   logic         fs    [N];
   logic         fd    [N];
   logic         bsy   [N];

   exp_bit_t expq [N][$];
   int       checks;
   int       errors;
   bit       mon_en;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .PAR_EN(1'b0)) u_msb (
      .clk(clk), .rst(rst_s[0]), .load_valid(lv[0]), .load_data(ld[0]),
      .load_ready(rdy[0]), .sout(so[0]), .sout_valid(sov[0]),
      .frame_start(fs[0]), .frame_done(fd[0]), .busy(bsy[0]));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .PAR_EN(1'b0)) u_lsb (
      .clk(clk), .rst(rst_s[1]), .load_valid(lv[1]), .load_data(ld[1]),
      .load_ready(rdy[1]), .sout(so[1]), .sout_valid(sov[1]),
      .frame_start(fs[1]), .frame_done(fd[1]), .busy(bsy[1]));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .PAR_EN(1'b1)) u_par (
      .clk(clk), .rst(rst_s[2]), .load_valid(lv[2]), .load_data(ld[2]),
      .load_ready(rdy[2]), .sout(so[2]), .sout_valid(sov[2]),
      .frame_start(fs[2]), .frame_done(fd[2]), .busy(bsy[2]));

   always #5 clk = ~clk;

   function automatic bit msb_of(input int i);
      return i != 1;
   endfunction

   function automatic int flen_of(input int i);
      return (i == 2) ? int'(W) + 1 : int'(W);
   endfunction

   function automatic void check(input string name, input int i,
                                 input logic [3:0] act, input logic [3:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %b want %b", name, i, $time, act, want);
      end
   endfunction

   // Reference frame: data bits in transmit order, then even parity when enabled
   function automatic void push_frame(input int i, input logic [W-1:0] d);
      int fl;
      fl = flen_of(i);
      for (int k = 0; k < fl; k++) begin
         exp_bit_t e;
         if (k < int'(W)) e.b = msb_of(i) ? d[int'(W) - 1 - k] : d[k];
         else             e.b = ^d;
         e.first = (k == 0);
         e.last  = (k == fl - 1);
         expq[i].push_back(e);
      end
   endfunction

   // Monitor: every cycle each DUT either presents the next expected bit or is idle
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < int'(N); i++) begin
            exp_bit_t e;
            logic     ev;
            logic     er;
            ev = (expq[i].size() > 0);
            check("valid_busy", i, {2'b00, sov[i], bsy[i]}, {2'b00, ev, ev});
            if (ev) begin
               e = expq[i].pop_front();
               check("frame_bit", i, {1'b0, so[i], fs[i], fd[i]},
                     {1'b0, e.b, e.first, e.last});
            end else begin
               check("idle_out", i, {1'b0, so[i], fs[i], fd[i]}, 4'b0000);
            end
            er = !rst_s[i] && (expq[i].size() == 0);
            check("load_ready", i, {3'b000, rdy[i]}, {3'b000, er});
         end
      end
   end

   // One input cycle; the model decides acceptance from its own view of the frame
   task automatic drive(input int i, input logic r, input logic v,
                        input logic [W-1:0] d, output bit acc);
      @(negedge clk);
      #1;
      rst_s[i] = r;
      lv[i]    = v;
      ld[i]    = d;
      acc = !r && v && (expq[i].size() == 0);
      if (r) expq[i].delete();
      if (acc) push_frame(i, d);
   endtask

   task automatic send(input int i, input logic [W-1:0] d);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
         drive(i, 1'b0, 1'b1, d, acc);
         n++;
      end
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout dut%0d word %h not accepted", i, d);
      end
   endtask

   task automatic idle(input int i, input int n);
      bit acc;
      for (int k = 0; k < n; k++) drive(i, 1'b0, 1'b0, W'($urandom), acc);
   endtask

   task automatic run_dut(input int i);
      bit acc;
      drive(i, 1'b1, 1'b1, 8'hA5, acc);
      drive(i, 1'b1, 1'b1, 8'h5A, acc);
      send(i, 8'hA5); idle(i, 12);
      send(i, 8'h0F); idle(i, 12);
      send(i, 8'h07); idle(i, 12);
      send(i, 8'hA5); idle(i, 12);
      send(i, 8'hFF); send(i, 8'h00); idle(i, 12);
      send(i, 8'hA5); idle(i, 3);
      drive(i, 1'b1, 1'b0, 8'h00, acc);
      send(i, 8'h3C); idle(i, 12);
      for (int n = 0; n < 60; n++) begin
         send(i, W'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            idle(i, int'($urandom_range(0, flen_of(i))));
            drive(i, 1'b1, 1'($urandom_range(0, 1)), W'($urandom), acc);
         end else begin
            idle(i, int'($urandom_range(0, 3)));
         end
      end
      idle(i, flen_of(i) + 2);
   endtask

   initial begin
      clk    = 1'b0;
      checks = 0;
      errors = 0;
      mon_en = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         rst_s[i] = 1'b1;
         lv[i]    = 1'b0;
         ld[i]    = '0;
      end
      fork
         run_dut(0);
         run_dut(1);
         run_dut(2);
      join
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
